// File: rtl/parking_pkg.sv
// Shared definitions for the car-park entry controller: state codes and
// occupancy counter width helper.
package parking_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE       = 3'd0,
        S_WAIT_PASS  = 3'd1,
        S_WRONG_PASS = 3'd2,
        S_RIGHT_PASS = 3'd3,
        S_STOP       = 3'd4,
        S_FULL       = 3'd5,
        S_LOCKED     = 3'd6
    } state_e;

    // Bits needed to hold 0..cap inclusive.
    function automatic int unsigned occ_w(input int unsigned cap);
        return (cap < 1) ? 1 : $clog2(cap + 1);
    endfunction

endpackage

// File: rtl/parking_occ_counter.sv
// Lot occupancy tracker: rising-edge detect on the exit sensor and a
// saturating up/down counter with a registered full flag.
module parking_occ_counter
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          exit_sensor_i,
    input  logic                          entry_i,
    output logic [occ_w(CAPACITY)-1:0]    occupancy_o,
    output logic                          lot_full_o
);

    localparam int unsigned      OCC_W = occ_w(CAPACITY);
    localparam logic [OCC_W-1:0] CAP_V = OCC_W'(CAPACITY);

    logic             exit_q;
    logic             exit_rise;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             full_q;

    assign exit_rise = exit_sensor_i & ~exit_q;

    // Simultaneous entry and exit cancel; each direction saturates.
    always_comb begin
        occ_d = occ_q;
        if (entry_i && !exit_rise) begin
            if (occ_q != CAP_V) occ_d = occ_q + 1'b1;
        end else if (exit_rise && !entry_i) begin
            if (occ_q != '0) occ_d = occ_q - 1'b1;
        end
    end

    // Full flag follows the next count so it never lags occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exit_q <= 1'b0;
            occ_q  <= '0;
            full_q <= 1'b0;
        end else begin
            exit_q <= exit_sensor_i;
            occ_q  <= occ_d;
            full_q <= (occ_d == CAP_V);
        end
    end

    assign occupancy_o = occ_q;
    assign lot_full_o  = full_q;

endmodule

// File: rtl/parking_lot_ctrl.sv
// Multi-bay gated car-park entry controller: password FSM, entry timeout,
// blinking status LEDs and occupancy tracking.
// Optional feature: define PARK_LOCKOUT_EN to lock the gate for LOCK_CYC
// cycles after MAX_TRIES wrong passwords.
module parking_lot_ctrl
    import parking_pkg::*;
#(
    parameter int unsigned       PASS_W    = 4,
    parameter logic [PASS_W-1:0] PASSWORD  = PASS_W'('hA),
    parameter int unsigned       CAPACITY  = 8,
    parameter int unsigned       WAIT_CYC  = 16,
    parameter int unsigned       BLINK_CYC = 4,
    parameter int unsigned       MAX_TRIES = 3,
    parameter int unsigned       LOCK_CYC  = 32
) (
    input  logic                        clock_in,
    input  logic                        rst_in,
    input  logic                        front_sensor,
    input  logic                        back_sensor,
    input  logic                        exit_sensor,
    input  logic                        pass_valid,
    input  logic [PASS_W-1:0]           pass_in,
    output logic                        gate_open,
    output logic                        g_led,
    output logic                        r_led,
    output logic                        lot_full,
    output logic [occ_w(CAPACITY)-1:0]  occupancy,
    output logic [STATE_W-1:0]          state_o
);

    localparam int unsigned TMR_MAX = (WAIT_CYC > LOCK_CYC) ? WAIT_CYC : LOCK_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned BLK_W   = $clog2(BLINK_CYC + 1);
    localparam int unsigned TRY_W   = $clog2(MAX_TRIES + 1);

    localparam logic [TMR_W-1:0] WAIT_LAST  = TMR_W'(WAIT_CYC - 1);
`ifdef PARK_LOCKOUT_EN
    localparam logic [TMR_W-1:0] LOCK_LAST  = TMR_W'(LOCK_CYC - 1);
`endif
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_CYC - 1);
    localparam logic [TRY_W-1:0] TRY_MAX    = TRY_W'(MAX_TRIES);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic               blink_q, blink_d;
    logic [TRY_W-1:0]   tries_q, tries_d, tries_inc;
    logic               gate_q, gate_d;
    logic               g_q, g_d;
    logic               r_q, r_d;
    logic               pass_ok, pass_bad;
    logic               entry;

    assign pass_ok   = pass_valid && (pass_in == PASSWORD);
    assign pass_bad  = pass_valid && (pass_in != PASSWORD);
    assign tries_inc = (tries_q == TRY_MAX) ? tries_q : tries_q + 1'b1;

    parking_occ_counter #(
        .CAPACITY (CAPACITY)
    ) u_occ (
        .clk_i         (clock_in),
        .rst_ni        (rst_in),
        .exit_sensor_i (exit_sensor),
        .entry_i       (entry),
        .occupancy_o   (occupancy),
        .lot_full_o    (lot_full)
    );

    // Next-state, tries bookkeeping and entry strobe.
    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        entry   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (front_sensor) state_d = lot_full ? S_FULL : S_WAIT_PASS;
            end
            S_FULL: begin
                if (!front_sensor)  state_d = S_IDLE;
                else if (!lot_full) state_d = S_WAIT_PASS;
            end
            S_WAIT_PASS: begin
                if (pass_ok) begin
                    state_d = S_RIGHT_PASS;
                end else if (pass_bad) begin
                    state_d = S_WRONG_PASS;
                    tries_d = tries_inc;
                end else if (tmr_q == WAIT_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_WRONG_PASS: begin
                if (pass_ok) begin
                    state_d = S_RIGHT_PASS;
                end else if (pass_bad) begin
                    tries_d = tries_inc;
`ifdef PARK_LOCKOUT_EN
                    if (tries_inc == TRY_MAX) state_d = S_LOCKED;
`endif
                end else if (!front_sensor) begin
                    state_d = S_IDLE;
                end
            end
            S_RIGHT_PASS: begin
                if (front_sensor && back_sensor) begin
                    state_d = S_STOP;
                end else if (back_sensor) begin
                    state_d = S_IDLE;
                    entry   = 1'b1;
                end
            end
            S_STOP: begin
                if (pass_ok) state_d = S_RIGHT_PASS;
            end
`ifdef PARK_LOCKOUT_EN
            S_LOCKED: begin
                if (tmr_q == LOCK_LAST) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE || state_d == S_RIGHT_PASS) tries_d = '0;
    end

    // One dwell timer serves both the entry timeout and the lockout period;
    // it only runs while staying in one of those two states.
    always_comb begin
        tmr_d = '0;
        if (state_d == state_q && (state_q == S_WAIT_PASS || state_q == S_LOCKED))
            tmr_d = tmr_q + 1'b1;
    end

    // Blink phase restarts high on every state change.
    always_comb begin
        if (state_d != state_q) begin
            blk_cnt_d = '0;
            blink_d   = 1'b1;
        end else if (blk_cnt_q == BLINK_LAST) begin
            blk_cnt_d = '0;
            blink_d   = ~blink_q;
        end else begin
            blk_cnt_d = blk_cnt_q + 1'b1;
            blink_d   = blink_q;
        end
    end

    // Output decode from the state being entered, so outputs line up with it.
    always_comb begin
        gate_d = 1'b0;
        g_d    = 1'b0;
        r_d    = 1'b0;
        case (state_d)
            S_WAIT_PASS, S_FULL:  r_d = 1'b1;
            S_WRONG_PASS, S_STOP: r_d = blink_d;
            S_RIGHT_PASS: begin
                gate_d = 1'b1;
                g_d    = blink_d;
            end
`ifdef PARK_LOCKOUT_EN
            S_LOCKED: begin
                r_d = 1'b1;
                g_d = blink_d;
            end
`endif
            default: ;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            blk_cnt_q <= '0;
            blink_q   <= 1'b0;
            tries_q   <= '0;
            gate_q    <= 1'b0;
            g_q       <= 1'b0;
            r_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            blk_cnt_q <= blk_cnt_d;
            blink_q   <= blink_d;
            tries_q   <= tries_d;
            gate_q    <= gate_d;
            g_q       <= g_d;
            r_q       <= r_d;
        end
    end

    assign gate_open = gate_q;
    assign g_led     = g_q;
    assign r_led     = r_q;
    assign state_o   = state_q;

endmodule
